comb_lut_engine: RTL and testbench

Registered, programmable multi-channel truth-table evaluator, the parametrised successor to our fixed sum-of-products logic blocks. Each of NUM_CH channels evaluates an arbitrary NUM_IN-input Boolean function through a 2^NUM_IN-entry lookup table. Inputs and results move over valid/ready streams. Tables are reprogrammed at run time through a shadow bank that is committed atomically once the pipeline has drained. The block sits between input-sampling logic and any downstream consumer of the decoded function outputs.

---
 rtl/comb_lut_engine_if.sv | 32 +++
 rtl/comb_lut_engine.sv | 108 ++++++++++
 tb/tb_comb_lut_engine.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comb_lut_engine_if.sv
// Stream and configuration bundle for comb_lut_engine.
// Slave side is the engine, master side is the driver or consumer.
interface comb_lut_engine_if #(
   parameter int NUM_IN = 4,
   parameter int NUM_CH = 2
);
   localparam int TBL = 1 << NUM_IN;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_CH*NUM_IN-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [NUM_CH-1:0]        out_data;
   logic                     cfg_wr;
   logic [CHW-1:0]           cfg_ch;
   logic [TBL-1:0]           cfg_table;
   logic                     cfg_commit;
   logic                     cfg_busy;
   logic                     cfg_err;

   modport master (
      output in_valid, in_data, out_ready, cfg_wr, cfg_ch, cfg_table, cfg_commit,
      input  in_ready, out_valid, out_data, cfg_busy, cfg_err
   );

   modport slave (
      input  in_valid, in_data, out_ready, cfg_wr, cfg_ch, cfg_table, cfg_commit,
      output in_ready, out_valid, out_data, cfg_busy, cfg_err
   );
endinterface

// File: rtl/comb_lut_engine.sv
// Multi-channel registered truth-table evaluator with a shadow table bank
// that is committed to the active bank once the output register has drained.
module comb_lut_lane #(
   parameter int             NUM_IN = 4,
   parameter int             TBL    = 16,
   parameter logic [TBL-1:0] INIT   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [TBL-1:0]    wr_table,
   input  logic              swap,
   input  logic              eval,
   input  logic [NUM_IN-1:0] idx,
   output logic              res
);
   logic [TBL-1:0] active, shadow;

   // eval and swap are mutually exclusive: inputs are never accepted in SWAP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= INIT;
         shadow <= INIT;
         res    <= 1'b0;
      end else begin
         if (wr_en) shadow <= wr_table;
         if (swap)  active <= shadow;
         if (eval)  res    <= active[idx];
      end
   end
endmodule

module comb_lut_engine #(
   parameter int NUM_IN = 4,
   parameter int NUM_CH = 2,
   parameter logic [NUM_CH*(1<<NUM_IN)-1:0] INIT_TABLE = 32'hEEE2_35A5
) (
   input logic               clk,
   input logic               rst_n,
   comb_lut_engine_if.slave  bus
);
   localparam int TBL = 1 << NUM_IN;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

   state_t                         state, state_nxt;
   logic                           out_valid_q, err_q;
   logic                           accept, swap, range_ok, wr_ok;
   logic [NUM_CH-1:0][NUM_IN-1:0]  idx;
   logic [NUM_CH-1:0]              res;

   assign idx          = bus.in_data;
   assign bus.in_ready = (state == RUN) & (~out_valid_q | bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;
   assign range_ok     = int'(bus.cfg_ch) < NUM_CH;
   assign wr_ok        = bus.cfg_wr & (state == RUN) & range_ok;

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = res;
   assign bus.cfg_busy  = (state != RUN);
   assign bus.cfg_err   = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= bus.cfg_wr & ~((state == RUN) & range_ok);
         if (accept)             out_valid_q <= 1'b1;
         else if (bus.out_ready) out_valid_q <= 1'b0;
      end
   end

   // DRAIN waits until the output register is empty or being emptied this cycle
   always_comb begin
      state_nxt = state;
      swap      = 1'b0;
      case (state)
         RUN:     if (bus.cfg_commit) state_nxt = DRAIN;
         DRAIN:   if (!out_valid_q || bus.out_ready) state_nxt = SWAP;
         SWAP: begin
            swap      = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      comb_lut_lane #(
         .NUM_IN (NUM_IN),
         .TBL    (TBL),
         .INIT   (INIT_TABLE[k*TBL +: TBL])
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_ok & (bus.cfg_ch == CHW'(k))),
         .wr_table (bus.cfg_table),
         .swap     (swap),
         .eval     (accept),
         .idx      (idx[k]),
         .res      (res[k])
      );
   end
endmodule

// File: tb/tb_comb_lut_engine.sv
// Directed bench for comb_lut_engine: default tables, backpressure, commit flow, errors, reset.
module tb_comb_lut_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   comb_lut_engine_if #(.NUM_IN(4), .NUM_CH(2)) bus ();
   comb_lut_engine_if #(.NUM_IN(4), .NUM_CH(3)) bus3 ();

   comb_lut_engine #(.NUM_IN(4), .NUM_CH(2), .INIT_TABLE(32'hEEE2_35A5)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   comb_lut_engine #(.NUM_IN(4), .NUM_CH(3), .INIT_TABLE(48'h00FF_EEE2_35A5)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3));

   function automatic logic e0(input int i);
      case (i)
         0, 2, 5, 7, 8, 10, 12, 13: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   function automatic logic e1(input int i);
      case (i)
         1, 5, 6, 7, 9, 10, 11, 13, 14, 15: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic eval(input logic [7:0] d, input logic [1:0] exp, input string name);
      bus.in_data   = d;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
         errors++;
         $display("FAIL %s: valid=%b data=%b, expected valid=1 data=%b", name, bus.out_valid, bus.out_data, exp);
      end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
      bus.cfg_wr = 0; bus.cfg_ch = '0; bus.cfg_table = '0; bus.cfg_commit = 0;
      bus3.in_valid = 0; bus3.in_data = '0; bus3.out_ready = 0;
      bus3.cfg_wr = 0; bus3.cfg_ch = '0; bus3.cfg_table = '0; bus3.cfg_commit = 0;
      rst_n = 1'b0;
      #12;
      checks++;
      if ({bus.out_valid, bus.out_data, bus.cfg_busy, bus.cfg_err, bus.in_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL reset: valid/data/busy/err/in_ready=%b, expected 000001",
                  {bus.out_valid, bus.out_data, bus.cfg_busy, bus.cfg_err, bus.in_ready});
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_sweep(input string name);
      logic [1:0] exp;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.in_data  = 8'(i);
         bus.in_valid = 1'b1;
         exp = {e1(i >> 4), e0(i & 15)};
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready idx=%0d: in_ready=%b, expected 1", name, i, bus.in_ready);
         end
         step();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d: valid=%b data=%b, expected valid=1 data=%b",
                     name, i, bus.out_valid, bus.out_data, exp);
         end
      end
      bus.in_valid = 1'b0;
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s drain: out_valid=%b, expected 0", name, bus.out_valid);
      end
   endtask

   task automatic test_backpressure();
      bus.in_data = 8'h30; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      step();
      bus.in_data = 8'hFF;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b01 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold c=%0d: valid=%b data=%b in_ready=%b, expected 1 01 0",
                     c, bus.out_valid, bus.out_data, bus.in_ready);
         end
         step();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b, expected 0", bus.out_valid);
      end
   endtask

   task automatic test_reprogram();
      bus.cfg_wr = 1'b1; bus.cfg_ch = 1'b0; bus.cfg_table = 16'h8000;
      step();
      bus.cfg_wr = 1'b0;
      checks++;
      if (bus.cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reprog_err: cfg_err=%b, expected 0", bus.cfg_err);
      end
      eval(8'h00, 2'b01, "reprog_shadow_only");
      bus.cfg_commit = 1'b1;
      step();
      bus.cfg_commit = 1'b0;
      checks++;
      if (bus.cfg_busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reprog_busy1: busy=%b in_ready=%b, expected 1 0", bus.cfg_busy, bus.in_ready);
      end
      step();
      checks++;
      if (bus.cfg_busy !== 1'b1) begin
         errors++;
         $display("FAIL reprog_busy2: busy=%b, expected 1", bus.cfg_busy);
      end
      step();
      checks++;
      if (bus.cfg_busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reprog_done: busy=%b in_ready=%b, expected 0 1", bus.cfg_busy, bus.in_ready);
      end
      eval(8'h0F, 2'b01, "reprog_chF");
      eval(8'hF0, 2'b10, "reprog_ch0");
      eval(8'h55, 2'b10, "reprog_ch1_kept");
   endtask

   task automatic test_commit_stalled();
      bus.cfg_wr = 1'b1; bus.cfg_ch = 1'b1; bus.cfg_table = 16'h0001;
      step();
      bus.cfg_wr = 1'b0;
      bus.in_data = 8'h10; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0; bus.cfg_commit = 1'b1;
      step();
      bus.cfg_commit = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 8'h00;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (bus.cfg_busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 2'b10) begin
            errors++;
            $display("FAIL stall_drain c=%0d: busy=%b in_ready=%b valid=%b data=%b, expected 1 0 1 10",
                     c, bus.cfg_busy, bus.in_ready, bus.out_valid, bus.out_data);
         end
         step();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      step();
      checks++;
      if (bus.cfg_busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_swap: busy=%b valid=%b, expected 1 0", bus.cfg_busy, bus.out_valid);
      end
      step();
      checks++;
      if (bus.cfg_busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_run: busy=%b, expected 0", bus.cfg_busy);
      end
      eval(8'h10, 2'b00, "stall_new_idx1");
      eval(8'h00, 2'b10, "stall_new_idx0");
   endtask

   task automatic test_errors();
      bus3.cfg_wr = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_table = 16'hFFFF;
      step();
      bus3.cfg_wr = 1'b0;
      checks++;
      if (bus3.cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL err_range: cfg_err=%b, expected 1", bus3.cfg_err);
      end
      bus3.cfg_wr = 1'b1; bus3.cfg_ch = 2'd2; bus3.cfg_table = 16'h00FF;
      step();
      bus3.cfg_wr = 1'b0;
      checks++;
      if (bus3.cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL err_valid_ch: cfg_err=%b, expected 0", bus3.cfg_err);
      end
      bus3.cfg_commit = 1'b1;
      step();
      bus3.cfg_commit = 1'b0;
      step(); step();
      bus3.out_ready = 1'b1; bus3.in_valid = 1'b1; bus3.in_data = 12'h000;
      step();
      checks++;
      if (bus3.out_valid !== 1'b1 || bus3.out_data !== 3'b101) begin
         errors++;
         $display("FAIL err_range_tbl0: valid=%b data=%b, expected 1 101", bus3.out_valid, bus3.out_data);
      end
      bus3.in_data = 12'hFFF;
      step();
      checks++;
      if (bus3.out_data !== 3'b010) begin
         errors++;
         $display("FAIL err_range_tblF: data=%b, expected 010", bus3.out_data);
      end
      bus3.in_valid = 1'b0;
      step();

      bus.in_data = 8'h00; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0; bus.cfg_commit = 1'b1;
      step();
      bus.cfg_commit = 1'b0;
      bus.cfg_wr = 1'b1; bus.cfg_ch = 1'b0; bus.cfg_table = 16'hFFFF;
      step();
      bus.cfg_wr = 1'b0;
      checks++;
      if (bus.cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL err_drain_pulse: cfg_err=%b, expected 1", bus.cfg_err);
      end
      step();
      checks++;
      if (bus.cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL err_drain_clear: cfg_err=%b, expected 0", bus.cfg_err);
      end
      bus.out_ready = 1'b1;
      step(); step();
      eval(8'h00, 2'b10, "err_drain_tbl0");
      eval(8'h11, 2'b00, "err_drain_tbl1");
   endtask

   task automatic test_reset_mid_drain();
      bus.cfg_wr = 1'b1; bus.cfg_ch = 1'b0; bus.cfg_table = 16'h0000;
      step();
      bus.cfg_wr = 1'b0;
      bus.in_data = 8'h77; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0; bus.cfg_commit = 1'b1;
      step();
      bus.cfg_commit = 1'b0;
      checks++;
      if (bus.cfg_busy !== 1'b1 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: busy=%b valid=%b, expected 1 1", bus.cfg_busy, bus.out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_data, bus.cfg_busy, bus.cfg_err, bus.in_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL rst_mid: valid/data/busy/err/in_ready=%b, expected 000001",
                  {bus.out_valid, bus.out_data, bus.cfg_busy, bus.cfg_err, bus.in_ready});
      end
      step();
      rst_n = 1'b1;
      step();
      test_sweep("rst_sweep");
   endtask

   initial begin
      test_reset();
      test_sweep("sweep");
      test_backpressure();
      test_reprogram();
      test_commit_stalled();
      test_errors();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
